par_to_serial: RTL and testbench

Byte serializer for the transmit path. It runs on the fastest generated clock (`clk4f`-class bit clock, one output bit per cycle) and consumes words produced in the slower domains. It emits a continuous MSB-first bit stream and inserts a comma/idle word whenever no valid data is offered. After every reset it transmits a fixed number of idle words before it accepts data, so the downstream deserializer can lock.

---
 rtl/par_to_serial.sv | 62 ++++++
 tb/tb_par_to_serial.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/par_to_serial.sv
// rtl/par_to_serial.sv - MSB-first word serializer with idle insertion and post-reset sync preamble
module par_to_serial #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   IDLE_WORD  = 8'hBC,
    parameter int                 SYNC_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             active_out
);
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [SCW-1:0] LAST_SYNC = SCW'(SYNC_WORDS - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SCW-1:0]   sync_cnt;
    logic [WIDTH-1:0] shreg;
    logic             act;

    // Data is accepted only in RUN; every other load edge injects the idle word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt      <= LAST_BIT;
            shreg    <= '0;
            state    <= SYNC;
            sync_cnt <= '0;
            act      <= 1'b0;
        end else if (cnt == LAST_BIT) begin
            cnt <= '0;
            if (state == RUN && valid_in) begin
                shreg <= data_in;
                act   <= 1'b1;
            end else begin
                shreg <= IDLE_WORD;
                act   <= 1'b0;
            end
            if (state == SYNC) begin
                if (sync_cnt == LAST_SYNC)
                    state <= RUN;
                else
                    sync_cnt <= sync_cnt + 1'b1;
            end
        end else begin
            cnt   <= cnt + 1'b1;
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign data_out    = shreg[WIDTH-1];
    assign frame_start = (cnt == '0);
    assign ready_out   = (state == RUN) && (cnt == LAST_BIT);
    assign active_out  = act;
endmodule

// File: tb/tb_par_to_serial.sv
// tb/tb_par_to_serial.sv - randomized self-checking bench for par_to_serial against a word-level stream model
module tb_par_to_serial;
    localparam int         W    = 8;
    localparam int         SYNC = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       active_out;

    int checks   = 0;
    int failures = 0;

    // Model: k counts edges since reset release; word index and bit position follow from k.
    int         k = 0;
    logic [7:0] cur = '0;
    logic       cur_act = 1'b0;
    logic [3:0] exp_o;
    logic [3:0] obs;

    par_to_serial #(.WIDTH(8), .IDLE_WORD(8'hBC), .SYNC_WORDS(4)) dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .frame_start(frame_start),
        .active_out(active_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        logic       v;
        logic [7:0] d;
        logic       r;
        int         pos;
        v = valid_in; d = data_in; r = reset_L;
        @(posedge clk); #1;
        pos = 0;
        if (!r) begin
            k = 0; cur_act = 1'b0;
        end else begin
            k++;
            pos = (k - 1) % W;
            if (pos == 0) begin
                if ((k - 1) / W >= SYNC && v) begin cur = d; cur_act = 1'b1; end
                else begin cur = IDLE; cur_act = 1'b0; end
            end
        end
        if (k == 0) exp_o = 4'b0000;
        else exp_o = {cur[W-1-pos], pos == 0, (k % W == 0) && (k / W >= SYNC), cur_act};
        obs = {data_out, frame_start, ready_out, active_out};
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_out !== 1'b1 && n < 2*W) begin
            tick();
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL wait_ready_outputs got=%b want=%b k=%0d", obs, exp_o, k);
            end
            n++;
        end
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready_timeout got=%b want=1", ready_out);
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0; valid_in = 1'b1; data_in = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold got=%b want=0000 cycle=%0d", obs, i);
            end
        end
    endtask

    task automatic test_sync();
        logic [31:0] bits = '0;
        logic [7:0]  hi = '0;
        int          first_rdy = -1;
        int          act_cnt = 0;
        reset_L = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL sync_outputs got=%b want=%b cycle=%0d", obs, exp_o, i + 1);
            end
            if (i < 32) begin
                bits = {bits[30:0], data_out};
                if (active_out) act_cnt++;
            end else hi = {hi[6:0], data_out};
            if (ready_out && first_rdy < 0) first_rdy = i + 1;
        end
        checks++;
        if (bits !== 32'hBCBCBCBC) begin failures++; $display("FAIL sync_bits got=%h want=bcbcbcbc", bits); end
        checks++;
        if (act_cnt != 0) begin failures++; $display("FAIL sync_active got=%0d want=0", act_cnt); end
        checks++;
        if (first_rdy != 32) begin failures++; $display("FAIL sync_first_ready got=%0d want=32", first_rdy); end
        checks++;
        if (hi !== 8'hFF) begin failures++; $display("FAIL sync_first_data got=%h want=ff", hi); end
    endtask

    task automatic test_single();
        logic [15:0] bits = '0;
        int          act_cnt = 0;
        logic        fs0 = 1'b0;
        valid_in = 1'b0;
        wait_ready();
        data_in = 8'hA5; valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin valid_in = 1'b0; fs0 = frame_start; end
            bits = {bits[14:0], data_out};
            if (active_out && i < 8) act_cnt++;
            if (active_out && i >= 8) act_cnt += 100;
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL single_outputs got=%b want=%b cycle=%0d", obs, exp_o, i);
            end
        end
        checks++;
        if (bits !== 16'hA5BC) begin failures++; $display("FAIL single_bits got=%h want=a5bc", bits); end
        checks++;
        if (act_cnt != 8) begin failures++; $display("FAIL single_active got=%0d want=8", act_cnt); end
        checks++;
        if (fs0 !== 1'b1) begin failures++; $display("FAIL single_frame_start got=%b want=1", fs0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits = '0;
        int          act_cnt = 0;
        int          rdy_a = -1, rdy_b = -1;
        wait_ready();
        valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = (i < 8) ? 8'h01 : 8'h80;
            tick();
            bits = {bits[14:0], data_out};
            if (active_out) act_cnt++;
            if (ready_out) begin if (rdy_a < 0) rdy_a = i; else if (rdy_b < 0) rdy_b = i; end
            checks++;
            if (frame_start && ready_out) begin
                failures++;
                $display("FAIL b2b_frame_ready_overlap got=1 want=0 cycle=%0d", i);
            end
        end
        valid_in = 1'b0;
        checks++;
        if (bits !== 16'h0180) begin failures++; $display("FAIL b2b_bits got=%h want=0180", bits); end
        checks++;
        if (act_cnt != 16) begin failures++; $display("FAIL b2b_active got=%0d want=16", act_cnt); end
        checks++;
        if (rdy_a != 7 || rdy_b != 15) begin
            failures++;
            $display("FAIL b2b_ready_spacing got=%0d,%0d want=7,15", rdy_a, rdy_b);
        end
    endtask

    task automatic test_idle();
        logic [31:0] bits = '0;
        int          act_cnt = 0;
        valid_in = 1'b0; data_in = 8'h55;
        wait_ready();
        for (int i = 0; i < 32; i++) begin
            tick();
            bits = {bits[30:0], data_out};
            if (active_out) act_cnt++;
        end
        checks++;
        if (bits !== 32'hBCBCBCBC) begin failures++; $display("FAIL idle_bits got=%h want=bcbcbcbc", bits); end
        checks++;
        if (act_cnt != 0) begin failures++; $display("FAIL idle_active got=%0d want=0", act_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL random_outputs got=%b want=%b k=%0d", obs, exp_o, k);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [2:0]  head = '0;
        logic [31:0] bits = '0;
        int          first_rdy = -1;
        wait_ready();
        data_in = 8'hA5; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            valid_in = 1'b0;
            head = {head[1:0], data_out};
        end
        checks++;
        if (head !== 3'b101) begin failures++; $display("FAIL midword_head got=%b want=101", head); end
        #3 reset_L = 1'b0;
        #1;
        checks++;
        if ({data_out, frame_start, ready_out, active_out} !== 4'b0000) begin
            failures++;
            $display("FAIL midword_async_clear got=%b want=0000",
                     {data_out, frame_start, ready_out, active_out});
        end
        for (int i = 0; i < 3; i++) tick();
        reset_L = 1'b1; valid_in = 1'b1; data_in = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            tick();
            bits = {bits[30:0], data_out};
            if (ready_out && first_rdy < 0) first_rdy = i + 1;
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL midword_outputs got=%b want=%b cycle=%0d", obs, exp_o, i + 1);
            end
        end
        checks++;
        if (bits !== 32'hBCBCBCBC) begin failures++; $display("FAIL midword_resync_bits got=%h want=bcbcbcbc", bits); end
        checks++;
        if (first_rdy != 32) begin failures++; $display("FAIL midword_first_ready got=%0d want=32", first_rdy); end
    endtask

    initial begin
        reset_L = 1'b0; valid_in = 1'b1; data_in = 8'hFF;
        test_reset();
        test_sync();
        test_single();
        test_back_to_back();
        test_idle();
        test_random();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
